rom_read_arbiter: RTL and testbench

ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

---
 rtl/rom_read_arbiter.sv | 115 +++++++++++
 tb/tb_rom_read_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: round-robin sharing of one registered ROM read port
// among NREQ requesters, with a single outstanding response, hold on
// backpressure and per-requester flush of the pending response.
module rom_read_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_addr,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_flush,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  input  logic                     rsp_ready,
  output logic                     mem_en,
  output logic                     mem_flush,
  output logic [WIDTH-1:0]         mem_addr,
  input  logic [WIDTH-1:0]         mem_rd
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   pend_id_q, pend_id_d;
  logic             pend_err_q, pend_err_d;

  logic [NREQ-1:0]  eligible;
  logic             busy;
  logic             pend_flushed;
  logic             pend_live;
  logic             can_grant;
  logic             gnt_found;
  logic             gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] sel_addr;

  // State, round-robin pointer and pending-response tag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDW'(NREQ - 1);
      pend_id_q  <= '0;
      pend_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      pend_id_q  <= pend_id_d;
      pend_err_q <= pend_err_d;
    end
  end

  // Arbitration, response presentation and next-state selection
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    pend_id_d  = pend_id_q;
    pend_err_d = pend_err_q;
    req_ready  = '0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    cand       = '0;
    gnt_found  = 1'b0;
    gnt_idx    = '0;

    eligible     = req_valid & ~req_flush;
    busy         = (state_q != IDLE);
    pend_flushed = busy && req_flush[pend_id_q];
    pend_live    = busy && !pend_flushed;
    can_grant    = rst_n && (!busy || rsp_ready || pend_flushed);

    // Walk downward so the nearest index after rr_ptr wins
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt      = can_grant && gnt_found;
    sel_addr = req_addr[gnt_idx*WIDTH +: WIDTH];

    rsp_valid = pend_live;
    rsp_id    = pend_id_q;
    rsp_err   = pend_live && pend_err_q;
    rsp_data  = pend_live ? mem_rd : '0;
    mem_flush = pend_flushed;

    if (gnt) begin
      req_ready  = NREQ'(1) << gnt_idx;
      mem_en     = 1'b1;
      mem_addr   = {sel_addr[WIDTH-1:2], 2'b00};
      pend_id_d  = gnt_idx;
      pend_err_d = (sel_addr[1:0] != 2'b00);
      rr_ptr_d   = gnt_idx;
      state_d    = RESP;
    end else if (pend_live && !rsp_ready) begin
      state_d = HOLD;
    end else begin
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter (NREQ=2, WIDTH=32) using a
// scoreboard of expected responses filled at each observed grant.
module tb_rom_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [1:0]  req_ready;
  logic [1:0]  req_flush;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic        mem_en;
  logic        mem_flush;
  logic [31:0] mem_addr;
  logic [31:0] memRd;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checkCount;
  int   errorCount;

  rom_read_arbiter #(.WIDTH(32), .NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .req_flush (req_flush),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .mem_en    (mem_en),
    .mem_flush (mem_flush),
    .mem_addr  (mem_addr),
    .mem_rd    (memRd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Registered ROM: new read wins, otherwise flush zeroes, otherwise hold
  always @(posedge clk) begin
    if (mem_en) memRd <= romWord(mem_addr);
    else if (mem_flush) memRd <= '0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle from a negedge, observe 2ns later, return at next negedge
  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [1:0] fl, input logic rr,
                               input logic chkG, input logic [1:0] expG);
    logic        flushFront;
    logic        allowed;
    logic [1:0]  elig;
    logic [31:0] addr;
    exp_t        e;
    req_valid = v;
    req_addr  = {a1, a0};
    req_flush = fl;
    rsp_ready = rr;
    #2;
    flushFront = (sb.size() > 0) && fl[sb[0].id];
    allowed    = (sb.size() == 0) || rr || flushFront;
    if (sb.size() > 0) begin
      if (flushFront) begin
        checkOutput("flushRspValid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("memFlush", {63'd0, mem_flush}, 64'd1);
        void'(sb.pop_front());
      end else begin
        checkOutput("rspValid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("rspId", {63'd0, rsp_id}, 64'(sb[0].id));
        checkOutput("rspData", {32'd0, rsp_data}, {32'd0, sb[0].data});
        checkOutput("rspErr", {63'd0, rsp_err}, {63'd0, sb[0].err});
        checkOutput("memFlushIdle", {63'd0, mem_flush}, 64'd0);
        if (rr) void'(sb.pop_front());
      end
    end else begin
      checkOutput("rspValidIdle", {63'd0, rsp_valid}, 64'd0);
      checkOutput("memFlushIdle", {63'd0, mem_flush}, 64'd0);
    end
    elig = v & ~fl;
    checkOutput("grantOneHot", {63'd0, ($countones(req_ready) <= 1)}, 64'd1);
    checkOutput("grantEligible", {62'd0, req_ready & ~elig}, 64'd0);
    checkOutput("grantIssued", {63'd0, (req_ready != 2'b00)}, {63'd0, (allowed && elig != 2'b00)});
    checkOutput("memEn", {63'd0, mem_en}, {63'd0, (req_ready != 2'b00)});
    if (chkG) checkOutput("grantSeq", {62'd0, req_ready}, {62'd0, expG});
    for (int i = 0; i < 2; i++) begin
      if (req_ready[i]) begin
        addr = (i == 1) ? a1 : a0;
        checkOutput("memAddr", {32'd0, mem_addr}, {32'd0, addr[31:2], 2'b00});
        e.id   = i;
        e.data = romWord({addr[31:2], 2'b00});
        e.err  = (addr[1:0] != 2'b00);
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  // Checks every output that must be zero while reset is asserted
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "ReqReady"}, {62'd0, req_ready}, 64'd0);
    checkOutput({tag, "RspValid"}, {63'd0, rsp_valid}, 64'd0);
    checkOutput({tag, "RspErr"}, {63'd0, rsp_err}, 64'd0);
    checkOutput({tag, "MemEn"}, {63'd0, mem_en}, 64'd0);
    checkOutput({tag, "MemFlush"}, {63'd0, mem_flush}, 64'd0);
  endtask

  // Directed scenarios followed by a constrained-random soak
  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_addr   = {32'h34, 32'h20};
    req_flush  = 2'b00;
    rsp_ready  = 1'b1;
    memRd      = '0;
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    $display("[TB] alternating grants");
    applyStimulus(2'b11, 32'h20, 32'h34, 2'b00, 1'b1, 1'b1, 2'b01);
    applyStimulus(2'b11, 32'h20, 32'h34, 2'b00, 1'b1, 1'b1, 2'b10);
    applyStimulus(2'b11, 32'h24, 32'h38, 2'b00, 1'b1, 1'b1, 2'b01);
    applyStimulus(2'b11, 32'h24, 32'h38, 2'b00, 1'b1, 1'b1, 2'b10);
    applyStimulus(2'b11, 32'h28, 32'h3C, 2'b00, 1'b1, 1'b1, 2'b01);
    applyStimulus(2'b11, 32'h28, 32'h3C, 2'b00, 1'b1, 1'b1, 2'b10);
    applyStimulus(2'b00, 32'h0,  32'h0,  2'b00, 1'b1, 1'b1, 2'b00);

    $display("[TB] single read and backpressure");
    applyStimulus(2'b01, 32'h10, 32'h0,  2'b00, 1'b1, 1'b1, 2'b01);
    applyStimulus(2'b11, 32'h10, 32'h13, 2'b00, 1'b0, 1'b1, 2'b00);
    applyStimulus(2'b11, 32'h10, 32'h13, 2'b00, 1'b0, 1'b1, 2'b00);
    applyStimulus(2'b11, 32'h10, 32'h13, 2'b00, 1'b0, 1'b1, 2'b00);
    applyStimulus(2'b10, 32'h10, 32'h13, 2'b00, 1'b1, 1'b1, 2'b10);

    $display("[TB] misaligned response and flush with regrant");
    applyStimulus(2'b01, 32'h40, 32'h0,  2'b00, 1'b1, 1'b1, 2'b01);
    applyStimulus(2'b10, 32'h0,  32'h44, 2'b01, 1'b1, 1'b1, 2'b10);
    applyStimulus(2'b00, 32'h0,  32'h0,  2'b00, 1'b1, 1'b1, 2'b00);

    $display("[TB] flush to idle and flush exclusion");
    applyStimulus(2'b01, 32'h50, 32'h0,  2'b00, 1'b1, 1'b1, 2'b01);
    applyStimulus(2'b00, 32'h0,  32'h0,  2'b01, 1'b1, 1'b1, 2'b00);
    applyStimulus(2'b00, 32'h0,  32'h0,  2'b00, 1'b1, 1'b1, 2'b00);
    applyStimulus(2'b11, 32'h54, 32'h58, 2'b01, 1'b1, 1'b1, 2'b10);
    applyStimulus(2'b00, 32'h0,  32'h0,  2'b00, 1'b1, 1'b1, 2'b00);

    $display("[TB] reset during hold");
    applyStimulus(2'b01, 32'h60, 32'h0,  2'b00, 1'b1, 1'b1, 2'b01);
    applyStimulus(2'b00, 32'h0,  32'h0,  2'b00, 1'b0, 1'b1, 2'b00);
    applyStimulus(2'b11, 32'h64, 32'h68, 2'b00, 1'b0, 1'b1, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("asyncReset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b11, 32'h70, 32'h74, 2'b00, 1'b1, 1'b1, 2'b01);
    applyStimulus(2'b00, 32'h0,  32'h0,  2'b00, 1'b1, 1'b1, 2'b00);

    $display("[TB] random soak");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(2'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                    ($urandom_range(0, 3) != 0), 1'b0, 2'b00);
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 2'b00);
    checkOutput("drainEmpty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
